// File: rtl/thres_dbuf_pkg.sv
// Shared types and helpers for the double-buffered PWM threshold store.
package thres_pkg;

    // Controller states: open for writes, waiting for the period boundary,
    // refreshing the new shadow bank from the new active bank.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        COPY = 2'd2
    } thres_state_t;

    // Flat entry index of (channel, field) in a bank.
    function automatic int unsigned entry_index(
        input int unsigned channel,
        input int unsigned field,
        input int unsigned num_fields
    );
        return channel * num_fields + field;
    endfunction

endpackage

// File: rtl/thres_dbuf_bank.sv
// One threshold bank: DEPTH entries in flops, one write port, one wide
// per-channel read port and one single-entry read port used as copy source.
module thres_dbuf_bank
    import thres_pkg::*;
#(
    parameter int PWM_WIDTH  = 16,
    parameter int NUM_PWM    = 4,
    parameter int NUM_FIELDS = 2,
    localparam int DEPTH = NUM_PWM * NUM_FIELDS,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(NUM_PWM),
    localparam int RW    = NUM_FIELDS * PWM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [PWM_WIDTH-1:0] wdata,
    input  logic [CW-1:0]        rd_chan,
    output logic [RW-1:0]        rd_chan_data,
    input  logic [AW-1:0]        rd_idx,
    output logic [PWM_WIDTH-1:0] rd_idx_data
);

    logic [PWM_WIDTH-1:0] mem [DEPTH];

    // Entry storage; writes beyond DEPTH are dropped silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Gather all fields of one channel; out-of-range channels read zero.
    always_comb begin
        rd_chan_data = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (entry_index(32'(rd_chan), f, NUM_FIELDS) < DEPTH) begin
                rd_chan_data[f*PWM_WIDTH +: PWM_WIDTH] =
                    mem[AW'(entry_index(32'(rd_chan), f, NUM_FIELDS))];
            end
        end
    end

    // Single-entry read for the copy sequencer.
    always_comb begin
        rd_idx_data = mem[rd_idx];
    end

endmodule

// File: rtl/thres_dbuf.sv
// Double-buffered PWM threshold store. The host fills the shadow bank,
// requests a commit, and the bank swap happens on a PWM period boundary so
// the comparators never see a half-updated set. After a swap the optional
// copy sequencer refreshes the new shadow bank from the new active bank.
//
// Write handshake: a write is taken on a rising clk edge when wr_valid and
// wr_ready are both high; wr_ready does not depend on wr_valid, and the host
// holds addr/data stable while wr_valid is high and wr_ready is low.
module thres_dbuf
    import thres_pkg::*;
#(
    parameter int PWM_WIDTH    = 16,
    parameter int NUM_PWM      = 4,
    parameter int NUM_FIELDS   = 2,
    parameter bit COPY_ON_SWAP = 1'b1,
    localparam int DEPTH = NUM_PWM * NUM_FIELDS,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(NUM_PWM),
    localparam int RW    = NUM_FIELDS * PWM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [AW-1:0]        wr_addr,
    input  logic [PWM_WIDTH-1:0] wr_data,
    input  logic                 commit_req,
    output logic                 commit_pending,
    input  logic                 period_end,
    output logic                 swapped,
    output logic                 busy,
    input  logic [CW-1:0]        rd_addr,
    output logic [RW-1:0]        rd_data
);

    thres_state_t         state;
    thres_state_t         state_nxt;
    logic                 act_bank;
    logic [AW-1:0]        copy_idx;
    logic                 copy_last;
    logic                 commit_latched;
    logic                 swap_now;
    logic                 ready_int;
    logic                 wr_fire;
    logic                 copy_we;
    logic [AW-1:0]        bank_waddr;
    logic [PWM_WIDTH-1:0] bank_wdata;
    logic [PWM_WIDTH-1:0] copy_src;
    logic                 we0;
    logic                 we1;
    logic [RW-1:0]        chan0;
    logic [RW-1:0]        chan1;
    logic [PWM_WIDTH-1:0] idx0;
    logic [PWM_WIDTH-1:0] idx1;
    logic                 swapped_q;
    logic [RW-1:0]        rd_q;

    assign copy_last = (copy_idx == AW'(DEPTH - 1));

    // Next-state and control decode; the swap fires on the edge where it is decided.
    always_comb begin
        state_nxt      = state;
        swap_now       = 1'b0;
        ready_int      = 1'b0;
        busy           = 1'b0;
        commit_pending = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (commit_req && period_end) begin
                    swap_now  = 1'b1;
                    state_nxt = COPY_ON_SWAP ? COPY : IDLE;
                end else if (commit_req) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                commit_pending = 1'b1;
                if (period_end) begin
                    swap_now  = 1'b1;
                    state_nxt = COPY_ON_SWAP ? COPY : IDLE;
                end
            end
            COPY: begin
                busy           = 1'b1;
                commit_pending = commit_latched;
                if (copy_last) begin
                    state_nxt = (commit_latched || commit_req) ? PEND : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // No writes are offered while reset is held.
    assign wr_ready = ready_int & ~rst;
    assign wr_fire  = wr_valid & wr_ready;
    assign copy_we  = (state == COPY);

    // Both banks share one write bus; only the shadow bank is enabled.
    assign copy_src   = act_bank ? idx1 : idx0;
    assign bank_waddr = copy_we ? copy_idx : wr_addr;
    assign bank_wdata = copy_we ? copy_src : wr_data;
    assign we0        = (act_bank == 1'b1) & (wr_fire | copy_we);
    assign we1        = (act_bank == 1'b0) & (wr_fire | copy_we);

    thres_dbuf_bank #(
        .PWM_WIDTH  (PWM_WIDTH),
        .NUM_PWM    (NUM_PWM),
        .NUM_FIELDS (NUM_FIELDS)
    ) u_bank0 (
        .clk          (clk),
        .rst          (rst),
        .we           (we0),
        .waddr        (bank_waddr),
        .wdata        (bank_wdata),
        .rd_chan      (rd_addr),
        .rd_chan_data (chan0),
        .rd_idx       (copy_idx),
        .rd_idx_data  (idx0)
    );

    thres_dbuf_bank #(
        .PWM_WIDTH  (PWM_WIDTH),
        .NUM_PWM    (NUM_PWM),
        .NUM_FIELDS (NUM_FIELDS)
    ) u_bank1 (
        .clk          (clk),
        .rst          (rst),
        .we           (we1),
        .waddr        (bank_waddr),
        .wdata        (bank_wdata),
        .rd_chan      (rd_addr),
        .rd_chan_data (chan1),
        .rd_idx       (copy_idx),
        .rd_idx_data  (idx1)
    );

    // Control state, bank select, copy index, latched commit and read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            act_bank       <= 1'b0;
            copy_idx       <= '0;
            commit_latched <= 1'b0;
            swapped_q      <= 1'b0;
            rd_q           <= '0;
        end else begin
            state     <= state_nxt;
            swapped_q <= swap_now;
            if (swap_now) begin
                act_bank <= ~act_bank;
            end
            if ((state == COPY) && !copy_last) begin
                copy_idx       <= copy_idx + AW'(1);
                commit_latched <= commit_latched | commit_req;
            end else begin
                copy_idx       <= '0;
                commit_latched <= 1'b0;
            end
            // Samples the bank active before this edge, so a swap-cycle read sees old data.
            rd_q <= act_bank ? chan1 : chan0;
        end
    end

    assign swapped = swapped_q;
    assign rd_data = rd_q;

endmodule

// File: tb/tb_thres_dbuf.sv
// Directed bench for thres_dbuf with default parameters (DEPTH = 8).
module tb_thres_dbuf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        commit_req = 1'b0;
    logic        commit_pending;
    logic        period_end = 1'b0;
    logic        swapped;
    logic        busy;
    logic [1:0]  rd_addr = '0;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;
    int bcnt;
    int guard;
    logic saw_swap;

    always #5 clk = ~clk;

    thres_dbuf #(
        .PWM_WIDTH    (16),
        .NUM_PWM      (4),
        .NUM_FIELDS   (2),
        .COPY_ON_SWAP (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit_req     (commit_req),
        .commit_pending (commit_pending),
        .period_end     (period_end),
        .swapped        (swapped),
        .busy           (busy),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Bounded wait for the copy sequencer to finish.
    task automatic wait_idle(input string tag);
        guard = 0;
        while (busy && guard < 40) begin
            step();
            guard++;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held.
        step();
        step();
        check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_swapped", {31'b0, swapped}, 32'd0);
        check("rst_pending", {31'b0, commit_pending}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        step();
        check("ready_after_rst", {31'b0, wr_ready}, 32'd1);

        for (int ch = 0; ch < 4; ch++) begin
            rd_addr = 2'(ch);
            step();
            check("init_read", rd_data, 32'd0);
        end

        // Write entry 2 without commit: not visible.
        wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
        check("ready_idle", {31'b0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        rd_addr = 2'd1;
        step();
        check("no_commit_invisible", rd_data, 32'd0);

        // Commit, period_end five cycles later.
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("pend_pending", {31'b0, commit_pending}, 32'd1);
        check("pend_ready_low", {31'b0, wr_ready}, 32'd0);
        repeat (4) step();
        check("pend_still_waiting", {31'b0, swapped}, 32'd0);
        check("pend_ready_low2", {31'b0, wr_ready}, 32'd0);
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        check("swap1_pulse", {31'b0, swapped}, 32'd1);
        check("swap1_old_read", rd_data, 32'd0);
        check("swap1_pending_clr", {31'b0, commit_pending}, 32'd0);
        bcnt = busy ? 1 : 0;
        step();
        check("swap1_new_read", rd_data, 32'h0000_1234);
        check("swap1_pulse_single", {31'b0, swapped}, 32'd0);
        guard = 0;
        while (busy && guard < 40) begin
            bcnt++;
            guard++;
            step();
        end
        check("swap1_busy_cycles", 32'(bcnt), 32'd8);
        check("swap1_ready_back", {31'b0, wr_ready}, 32'd1);

        // Partial update: only entry 3 written, copy keeps entry 2.
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        step();
        wr_valid = 1'b0;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        check("swap2_pulse", {31'b0, swapped}, 32'd1);
        check("swap2_old_read", rd_data, 32'h0000_1234);
        bcnt = busy ? 1 : 0;
        step();
        check("swap2_new_read", rd_data, 32'hBEEF_1234);
        guard = 0;
        while (busy && guard < 40) begin
            bcnt++;
            guard++;
            step();
        end
        check("swap2_busy_cycles", 32'(bcnt), 32'd8);

        // Write + commit + period_end in one IDLE cycle.
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'h00FF;
        commit_req = 1'b1; period_end = 1'b1; rd_addr = 2'd0;
        step();
        wr_valid = 1'b0; commit_req = 1'b0; period_end = 1'b0;
        check("swap3_pulse", {31'b0, swapped}, 32'd1);
        check("swap3_old_read", rd_data, 32'd0);
        check("swap3_busy", {31'b0, busy}, 32'd1);
        step();
        check("swap3_ch0", rd_data, 32'h0000_00FF);
        rd_addr = 2'd1;
        step();
        check("swap3_ch1_copied", rd_data, 32'hBEEF_1234);
        wait_idle("swap3_copy_done");

        // commit_req and period_end during COPY.
        commit_req = 1'b1; period_end = 1'b1;
        step();
        commit_req = 1'b0; period_end = 1'b0;
        check("swap4_pulse", {31'b0, swapped}, 32'd1);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        check("copy_pending_latched", {31'b0, commit_pending}, 32'd1);
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        check("copy_no_swap", {31'b0, swapped}, 32'd0);
        saw_swap = 1'b0;
        guard = 0;
        while (busy && guard < 40) begin
            if (swapped) saw_swap = 1'b1;
            guard++;
            step();
        end
        check("copy_no_swap_all", {31'b0, saw_swap}, 32'd0);
        check("copy_exit_busy", {31'b0, busy}, 32'd0);
        check("copy_exit_pend", {31'b0, commit_pending}, 32'd1);
        check("copy_exit_ready_low", {31'b0, wr_ready}, 32'd0);
        step();
        check("pend_no_swap_yet", {31'b0, swapped}, 32'd0);
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        check("swap5_pulse", {31'b0, swapped}, 32'd1);
        check("swap5_ch1", rd_data, 32'hBEEF_1234);
        wait_idle("swap5_copy_done");

        // Reset in the third cycle of COPY.
        wr_valid = 1'b1; wr_addr = 3'd6; wr_data = 16'h5A5A;
        commit_req = 1'b1; period_end = 1'b1;
        step();
        wr_valid = 1'b0; commit_req = 1'b0; period_end = 1'b0;
        check("swap6_busy", {31'b0, busy}, 32'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_swapped", {31'b0, swapped}, 32'd0);
        check("abort_pending", {31'b0, commit_pending}, 32'd0);
        check("abort_ready", {31'b0, wr_ready}, 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("abort_ready_back", {31'b0, wr_ready}, 32'd1);
        for (int ch = 0; ch < 4; ch++) begin
            rd_addr = 2'(ch);
            step();
            check("abort_read_zero", rd_data, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
